sae_msg_sequencer: RTL
======================

Name: sae_msg_sequencer

Overview:
- Upstream feeder for the sae core. It accepts a framed byte stream (plaintext or ciphertext) plus mode and key, then issues one sae transaction per byte.
- Each sae result is collected into an output FIFO and presented as a framed byte stream.
- Error flags, response timeouts and message framing are handled here so software and the bench never drive sae pulse-by-pulse.

Parameters:
- FIFO_DEPTH, 4, result FIFO entries; power of two, at least 2.
- TIMEOUT, 15, maximum cycles from sae_valid to a sae response before abort; at least 2.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_mode  in  2  01 keygen, 10 encrypt, 11 decrypt, 00 reserved; latched on accepted start.
- cfg_key  in  8  private or public key; latched on accepted start.
- start  in  1  begin message; accepted only in IDLE.
- busy  out  1  high whenever state is not IDLE.
- s_valid  in  1  input byte valid.
- s_ready  out  1  input byte accepted when s_valid & s_ready.
- s_data  in  8  input byte.
- s_last  in  1  final byte of message.
- sae_mode  out  2  drives sae mode.
- sae_data  out  8  drives sae data_input.
- sae_key  out  8  drives sae key_input.
- sae_valid  out  1  drives sae inputs_valid; one-cycle pulse.
- sae_ready  in  1  sae output_ready.
- sae_dout  in  8  sae data_output.
- sae_err_ptxt / sae_err_key / sae_err_ctxt  in  1 each  sae error flags.
- m_valid  out  1  output byte valid.
- m_ready  in  1  consumer ready.
- m_data  out  8  output byte.
- m_last  out  1  final byte of a successfully completed message.
- done  out  1  one-cycle pulse at end of message.
- status  out  3  bit0 char error, bit1 key error, bit2 timeout; sticky until next accepted start.

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE, mode/key registers 0, timeout counter 0.
- Reset asserted mid-message aborts immediately: FIFO is discarded and no done pulse is generated.
- States: IDLE, FETCH, ISSUE, WAIT, DRAIN, FINISH.
- IDLE:
  - start=1 latches cfg_mode and cfg_key and clears status.
  - Next state: FETCH for modes 10/11; ISSUE for mode 01, with sae_data=0 and no input consumed.
  - Reserved mode 00 sets status[1] and goes to FINISH.
- FETCH:
  - s_ready = (FIFO count < FIFO_DEPTH).
  - On handshake: register s_data and s_last, go to ISSUE.
  - At most one sae transaction is outstanding, so a result push can never overflow the FIFO.
- ISSUE: sae_valid=1 for exactly one cycle with registered mode, key and data; go to WAIT; timeout counter cleared.
- WAIT:
  - A response is the first cycle with sae_ready or any sae_err_* high. The sae core responds one cycle after sae_valid.
  - No error: push sae_dout into the FIFO. Its last flag is the registered s_last (always 1 in keygen). Next state is FINISH if last, otherwise FETCH.
  - Any error: no push. Set status[0] for ptxt/ctxt errors and status[1] for key errors. Next state is FINISH if the byte was last, otherwise DRAIN.
  - No response after TIMEOUT cycles: set status[2], apply the same last/DRAIN rule.
- DRAIN: s_ready=1; input bytes are discarded; the handshake carrying s_last goes to FINISH.
- FINISH:
  - Waits until the FIFO is empty (all bytes accepted downstream).
  - Then pulses done for one cycle and returns to IDLE. busy drops the same cycle as the done pulse.
- After an error, bytes already pushed are still delivered, but m_last is never asserted for that message. The consumer frames on done/status.
- Output FIFO:
  - First-word-fall-through: m_valid is high whenever the FIFO is non-empty.
  - Push and pop in the same cycle when full is legal; count stays unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- start while busy is ignored: no latch and no status change.
- Throughput: 3 cycles per byte (FETCH, ISSUE, WAIT) with no backpressure.

Optional Feature:
- Macro: SAE_SEQ_BYTE_COUNT_EN.
- When defined: adds output byte_count (16 bits). It is cleared on accepted start and increments on each FIFO push, saturating at 16'hFFFF. It holds after done until the next start and resets to 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Keygen: cfg_mode=01, cfg_key=8'h1B, start; sae stub returns 8'h2C after 1 cycle -> one sae_valid pulse with data 8'h00, m_data=8'h2C with m_last=1, done pulse, status=000.
- Encrypt "abc" (stub returns data+1), m_ready toggling 1/0 -> m_data 62,63,64 in order, m_last only on 64, exactly 3 sae_valid pulses, done after last pop.
- Encrypt 4 bytes, stub raises sae_err_ptxt on byte 2 -> byte 1 output only, bytes 3-4 drained with s_ready=1, status=001, m_last never asserted, done pulse.
- Stub never responds -> done pulse exactly TIMEOUT+3 cycles after start with status=100 (single-byte message); start pulsed while busy is ignored.
- FIFO_DEPTH=2, m_ready=0, 5-byte message -> s_ready low after 2 results stored, releases on pop; rst pulsed mid-message -> all outputs 0 next edge, no done.
- SAE_SEQ_BYTE_COUNT_EN defined, 3 good bytes -> byte_count=3 at done, 0 after next start.

Source files
------------

// File: rtl/sae_msg_sequencer.sv
// -----------------------------------------------------------------------------
// sae_msg_sequencer
//
// Upstream feeder for the sae core. A framed byte stream (plaintext or
// ciphertext) is accepted together with a mode and key, one sae transaction is
// issued per byte, and every good sae result is queued in a small
// first-word-fall-through FIFO and presented as a framed output stream.
// Error flags, response timeouts and message framing are all handled here.
//
// Optional feature macro: SAE_SEQ_BYTE_COUNT_EN
//   When defined, adds the 16-bit output byte_count. It counts FIFO pushes for
//   the current message, saturates at 16'hFFFF and clears on an accepted start.
//
// Parameters:
//   FIFO_DEPTH  result FIFO entries (power of two, >= 2)
//   TIMEOUT     cycles allowed in WAIT for a sae response (>= 2)
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   cfg_mode, cfg_key        mode/key, latched when start is accepted in IDLE
//   start, busy, done        message start, activity flag, end-of-message pulse
//   s_valid/s_ready/s_data/s_last   input byte stream
//   sae_mode/sae_data/sae_key/sae_valid   request to the sae core
//   sae_ready/sae_dout/sae_err_*          response from the sae core
//   m_valid/m_ready/m_data/m_last         output byte stream
//   status                   {timeout, key error, char error}, sticky per message
//   byte_count               (optional) pushed result count
// -----------------------------------------------------------------------------
module sae_msg_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cfg_mode,
    input  logic [7:0] cfg_key,
    input  logic       start,
    output logic       busy,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic [1:0] sae_mode,
    output logic [7:0] sae_data,
    output logic [7:0] sae_key,
    output logic       sae_valid,
    input  logic       sae_ready,
    input  logic [7:0] sae_dout,
    input  logic       sae_err_ptxt,
    input  logic       sae_err_key,
    input  logic       sae_err_ctxt,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic       done,
    output logic [2:0] status
`ifdef SAE_SEQ_BYTE_COUNT_EN
    ,
    output logic [15:0] byte_count
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        DRAIN  = 3'd4,
        FINISH = 3'd5
    } state_t;

    state_t            state_q;
    logic [1:0]        mode_q;
    logic [7:0]        key_q;
    logic [7:0]        data_q;
    logic              last_q;
    logic              saeValid_q;
    logic              done_q;
    logic [2:0]        status_q;
    logic [TO_W-1:0]   tmo_q;

    logic [7:0]        fifoMem_q  [FIFO_DEPTH];
    logic              fifoLast_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrPtr_q;
    logic [PTR_W-1:0]  wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q;
    logic [PTR_W-1:0]  rdPtr_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    logic              fifoNotEmpty;
    logic              inHandshake;
    logic              errChar;
    logic              errKey;
    logic              errAny;
    logic              response;
    logic              timeoutHit;
    logic              push;
    logic              pop;
    logic              startAccepted;

    // Response decode from the sae core. Any error flag counts as a response
    // so that a failing byte never has to wait out the timeout.
    always_comb begin
        errChar       = sae_err_ptxt | sae_err_ctxt;
        errKey        = sae_err_key;
        errAny        = errChar | errKey;
        response      = sae_ready | errAny;
        timeoutHit    = (tmo_q == TO_W'(TIMEOUT - 1));
        fifoNotEmpty  = (count_q != '0);
        startAccepted = (state_q == IDLE) && start;
    end

    // Input readiness. In FETCH a byte is only taken when the FIFO still has
    // room for its result; since only one sae transaction is ever in flight,
    // that single free slot is enough to guarantee the later push fits.
    // In DRAIN the rest of a failed message is swallowed as fast as it comes.
    always_comb begin
        s_ready = 1'b0;
        if (state_q == FETCH) begin
            s_ready = (count_q < CNT_W'(FIFO_DEPTH));
        end else if (state_q == DRAIN) begin
            s_ready = 1'b1;
        end
        inHandshake = s_valid & s_ready;
    end

    // FIFO push/pop strobes and next pointer/count values. Pointers are a
    // power-of-two width so they wrap naturally modulo FIFO_DEPTH.
    always_comb begin
        push    = (state_q == WAIT) && response && !errAny;
        pop     = fifoNotEmpty && m_ready;
        wrPtr_d = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d = pop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Message sequencer. One always_ff holds the state and every registered
    // output (sae request fields, sae_valid, done, status). sae_valid and done
    // default low each cycle so they can only ever be one-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= 2'b00;
            key_q      <= 8'h00;
            data_q     <= 8'h00;
            last_q     <= 1'b0;
            saeValid_q <= 1'b0;
            done_q     <= 1'b0;
            status_q   <= 3'b000;
            tmo_q      <= '0;
        end else begin
            saeValid_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q   <= cfg_mode;
                        key_q    <= cfg_key;
                        status_q <= 3'b000;
                        case (cfg_mode)
                            2'b01: begin
                                data_q     <= 8'h00;
                                last_q     <= 1'b1;
                                saeValid_q <= 1'b1;
                                state_q    <= ISSUE;
                            end
                            2'b10, 2'b11: begin
                                state_q <= FETCH;
                            end
                            default: begin
                                status_q <= 3'b010;
                                state_q  <= FINISH;
                            end
                        endcase
                    end
                end
                FETCH: begin
                    if (inHandshake) begin
                        data_q     <= s_data;
                        last_q     <= s_last;
                        saeValid_q <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    tmo_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (response) begin
                        if (errAny) begin
                            status_q[0] <= status_q[0] | errChar;
                            status_q[1] <= status_q[1] | errKey;
                            state_q     <= last_q ? FINISH : DRAIN;
                        end else begin
                            state_q <= last_q ? FINISH : FETCH;
                        end
                    end else if (timeoutHit) begin
                        status_q[2] <= 1'b1;
                        state_q     <= last_q ? FINISH : DRAIN;
                    end else begin
                        tmo_q <= tmo_q + TO_W'(1);
                    end
                end
                DRAIN: begin
                    if (inHandshake && s_last) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    if (count_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // FIFO bookkeeping. Reset throws away anything queued, which is what
    // makes a mid-message reset a clean abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // FIFO storage. The payload needs no reset because the outputs are gated
    // by the non-empty flag; the last flag travels alongside each byte.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q]  <= sae_dout;
            fifoLast_q[wrPtr_q] <= last_q;
        end
    end

`ifdef SAE_SEQ_BYTE_COUNT_EN
    logic [15:0] byteCount_q;

    // Per-message result counter. It restarts on an accepted start and
    // otherwise holds, so software can read it after done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byteCount_q <= 16'h0000;
        end else if (startAccepted) begin
            byteCount_q <= 16'h0000;
        end else if (push && (byteCount_q != 16'hFFFF)) begin
            byteCount_q <= byteCount_q + 16'h0001;
        end
    end

    assign byte_count = byteCount_q;
`else
    logic unusedStart;
    assign unusedStart = startAccepted;
`endif

    // Output drive. The output stream is first-word-fall-through, so the head
    // entry is visible whenever the FIFO holds anything.
    assign busy      = (state_q != IDLE);
    assign sae_mode  = mode_q;
    assign sae_key   = key_q;
    assign sae_data  = data_q;
    assign sae_valid = saeValid_q;
    assign done      = done_q;
    assign status    = status_q;
    assign m_valid   = fifoNotEmpty;
    assign m_data    = fifoNotEmpty ? fifoMem_q[rdPtr_q] : 8'h00;
    assign m_last    = fifoNotEmpty & fifoLast_q[rdPtr_q];

endmodule
